// File: rtl/mux_4in_rr_arbiter.sv
// rtl/mux_4in_rr_arbiter.sv - 4-requester round-robin arbiter driving a registered 4:1 bit mux
// Optional HOLD_TIMEOUT_EN: caps a single owner at HOLD_MAX consecutive grant cycles while others wait.
module mux_4in_rr_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] I,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       Q,
    output logic       valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] last;

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("HOLD_MAX must be within 2..255");
    end

    // Rotate requests so bit 0 is the requester right after the last winner.
    logic [7:0] req_twice;
    logic [2:0] rot_amount;
    logic [3:0] req_rot;
    logic [1:0] rot_offset;
    logic       rr_any;
    logic [1:0] rr_winner;

    always_comb begin
        req_twice  = {req, req};
        rot_amount = {1'b0, last} + 3'd1;
        req_rot    = 4'(req_twice >> rot_amount);
        rr_any     = |req;
        rot_offset = 2'd0;
        casez (req_rot)
            4'b???1: rot_offset = 2'd0;
            4'b??10: rot_offset = 2'd1;
            4'b?100: rot_offset = 2'd2;
            4'b1000: rot_offset = 2'd3;
            default: rot_offset = 2'd0;
        endcase
        rr_winner = last + 2'd1 + rot_offset;
    end

    logic owner_req;
    logic data_ok;

    assign owner_req = req[sel];
    assign data_ok   = (state == GRANT) && owner_req;

    logic timeout;

`ifdef HOLD_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    logic [7:0] hold_cnt;
    logic       others_waiting;

    assign others_waiting = |(req & ~gnt);
    assign timeout        = (state == GRANT) && (hold_cnt == HOLD_LAST) && others_waiting;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            sel   <= 2'b00;
            last  <= 2'b11;
            Q     <= 1'b0;
            valid <= 1'b0;
`ifdef HOLD_TIMEOUT_EN
            hold_cnt <= 8'd0;
`endif
        end else begin
            valid <= data_ok;
            Q     <= data_ok & I[sel];

            case (state)
                IDLE: begin
                    if (rr_any) begin
                        state <= GRANT;
                        gnt   <= 4'b0001 << rr_winner;
                        sel   <= rr_winner;
                        last  <= rr_winner;
`ifdef HOLD_TIMEOUT_EN
                        hold_cnt <= 8'd0;
`endif
                    end
                end
                GRANT: begin
                    // last equals sel here, so the owner is searched last and only wins when alone.
                    if (!owner_req || timeout) begin
                        if (rr_any) begin
                            gnt  <= 4'b0001 << rr_winner;
                            sel  <= rr_winner;
                            last <= rr_winner;
`ifdef HOLD_TIMEOUT_EN
                            hold_cnt <= 8'd0;
`endif
                        end else begin
                            state <= IDLE;
                            gnt   <= 4'b0000;
`ifdef HOLD_TIMEOUT_EN
                            hold_cnt <= 8'd0;
`endif
                        end
                    end else begin
`ifdef HOLD_TIMEOUT_EN
                        if (hold_cnt != HOLD_LAST) begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: doc/mux_4in_rr_arbiter.md
MUX_4IN_RR_ARBITER -- requirements
Module: mux_4in_rr_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 8: maximum consecutive grant cycles per requester; used only when HOLD_TIMEOUT_EN is defined; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  4  request, one bit per requester 0..3; level-sensitive.
REQ-005 I  input  4  data, one bit per requester; I[k] belongs to requester k.
REQ-006 gnt  output  4  registered one-hot grant, or 0000 when no requester is granted.
REQ-007 sel  output  2  registered index of the granted requester; drives the 4:1 mux select.
REQ-008 Q  output  1  registered mux output I[sel]; forced to 0 when valid is 0.
REQ-009 valid  output  1  registered; 1 when Q carries data from a granted, still-requesting source.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (no grant) and GRANT (exactly one gnt bit set).
REQ-011 Winner selection SHALL use round-robin priority: search (last+1) mod 4, (last+2) mod 4, and so on with wrap; the first set req bit wins; last is the internal 2-bit pointer to the most recent winner.
REQ-012 IDLE: if req != 0 at edge t, then at t+1 state=GRANT, gnt=onehot(winner), sel=winner, last=winner; if req == 0, remain IDLE.
REQ-013 GRANT with req[sel]=1 SHALL hold gnt, sel and last unchanged (subject to REQ-018).
REQ-014 GRANT with req[sel]=0 at edge t: if any other req bit is set, the next winner SHALL be granted at t+1 with no idle bubble; otherwise state=IDLE and gnt=0000 at t+1, with sel keeping its last value.
REQ-015 Data path: at every edge, valid <= (state==GRANT && req[sel]), and Q <= that same condition ? I[sel] : 0. Latency from req to first valid data is 2 cycles.
REQ-016 A re-request by the releasing requester in the same cycle as its release SHALL NOT win over other pending requesters; if it is the only requester, it SHALL be re-granted.
REQ-017 gnt SHALL never have more than one bit set, and sel SHALL always equal the index of the set gnt bit whenever gnt != 0.

Reset
REQ-019 While rst=1 at an edge: state=IDLE, gnt=0000, sel=00, Q=0, valid=0, last=11 (so requester 0 has the highest priority after reset), hold counter=0.
REQ-020 Reset SHALL take effect in the middle of a grant; req is ignored during the reset cycle.
REQ-021 After rst falls, arbitration SHALL resume on the first edge, per REQ-012.

Configuration
REQ-022 Macro HOLD_TIMEOUT_EN.
- Defined: an 8-bit hold counter clears on every new grant and increments each GRANT cycle, saturating at HOLD_MAX-1.
- REQ-018 (defined only): when the counter equals HOLD_MAX-1 and another req bit is set, the grant SHALL rotate to the next winner at the next edge even if req[sel]=1. A single owner is therefore granted at most HOLD_MAX consecutive cycles while others wait.
- Not defined: no counter and no HOLD_MAX logic; the owner keeps the grant for as long as req[sel]=1.

Verification
REQ-023 Reset: rst=1 for 2 cycles with req=1111 -> gnt=0000, sel=00, Q=0, valid=0; 1 cycle after rst falls -> gnt=0001, sel=00.
REQ-024 Single request: req=0100, I=0100 from IDLE at t -> gnt=0100, sel=10 at t+1; valid=1, Q=1 at t+2. Drop req at t+3 -> gnt=0000 at t+4 and valid=0, Q=0 at t+4.
REQ-025 Round-robin: each owner holds req 1 cycle after grant, then drops and re-raises it; all others held at 1 -> grant order 0001, 0010, 0100, 1000, 0001, with no idle cycle between grants.
REQ-026 Release with a pending request: owner 1 drops req while req=1001 -> next gnt=1000 (search starts at index 2), not 0001.
REQ-027 Timeout with HOLD_MAX=4 and req=0011 held constant: with HOLD_TIMEOUT_EN defined -> gnt pattern is 0001 for 4 cycles, then 0010 for 4 cycles, repeating; without the macro -> gnt stays 0001 indefinitely.
REQ-028 Reset mid-grant: gnt=0100, counter=2, rst pulsed 1 cycle -> gnt=0000, valid=0 on that edge; with req=0100 still held -> gnt=0100 one cycle after rst falls, with the counter restarted at 0.
